// File: rtl/calc_operand_entry.sv
// Keypad-to-operand entry controller for the BCD calculator.
// Turns single key presses into BCD operand A, an operator code and BCD
// operand B, and hands A/op/B to the ALU through a request/valid handshake.
module calc_operand_entry #(
   parameter int DIGITS = 4
) (
   input  logic                clk,
   input  logic                clear,
   input  logic                key_valid,
   input  logic [4:0]          key_code,
   input  logic [4*DIGITS-1:0] result,
   input  logic                result_valid,
   output logic [4*DIGITS-1:0] bcd_a,
   output logic [4*DIGITS-1:0] bcd_b,
   output logic [3:0]          opcode,
   output logic                exec_req,
   output logic [1:0]          state,
   output logic                digit_ovf
);

   localparam int W  = 4 * DIGITS;
   localparam int CW = $clog2(DIGITS + 1);
   localparam logic [CW-1:0] FULL = CW'(DIGITS);
   localparam logic [CW-1:0] ONE  = CW'(1);

   localparam logic [1:0] S_A    = 2'd0;
   localparam logic [1:0] S_OP   = 2'd1;
   localparam logic [1:0] S_B    = 2'd2;
   localparam logic [1:0] S_WAIT = 2'd3;

   logic          key_q_reg;
   logic [W-1:0]  a_reg, a_next;
   logic [W-1:0]  b_reg, b_next;
   logic [CW-1:0] a_cnt_reg, a_cnt_next;
   logic [CW-1:0] b_cnt_reg, b_cnt_next;
   logic [3:0]    opcode_reg, opcode_next;
   logic          exec_reg, exec_next;
   logic          fresh_reg, fresh_next;
   logic          ovf_reg, ovf_next;
   logic [1:0]    state_reg, state_next;

   logic          press;
   logic          is_digit, is_op, is_eq, is_bs, is_ce;
   logic [W-1:0]  digit_ext;

   // Key decode; a press is the rising edge of key_valid, so holding a key
   // produces exactly one event.
   assign press     = key_valid & ~key_q_reg;
   assign is_digit  = press && (key_code <= 5'd9);
   assign is_op     = press && (key_code >= 5'd10) && (key_code <= 5'd13);
   assign is_eq     = press && (key_code == 5'd14);
   assign is_bs     = press && (key_code == 5'd15);
   assign is_ce     = press && (key_code == 5'd16);
   assign digit_ext = {{(W-4){1'b0}}, key_code[3:0]};

   // Next-state and operand update logic for the entry FSM.
   always_comb begin
      a_next      = a_reg;
      b_next      = b_reg;
      a_cnt_next  = a_cnt_reg;
      b_cnt_next  = b_cnt_reg;
      opcode_next = opcode_reg;
      exec_next   = exec_reg;
      fresh_next  = fresh_reg;
      ovf_next    = ovf_reg;
      state_next  = state_reg;

      if (is_ce && (state_reg != S_WAIT)) begin
         // Clear-entry; never honoured while the ALU handshake is open.
         a_next      = '0;
         b_next      = '0;
         a_cnt_next  = '0;
         b_cnt_next  = '0;
         opcode_next = 4'd0;
         fresh_next  = 1'b0;
         ovf_next    = 1'b0;
         state_next  = S_A;
      end else begin
         case (state_reg)
            S_A: begin
               if (is_digit) begin
                  if (fresh_reg) begin
                     // A typed digit after a result starts a new operand.
                     a_next     = digit_ext;
                     a_cnt_next = ONE;
                     fresh_next = 1'b0;
                  end else if (a_cnt_reg == FULL) begin
                     ovf_next = 1'b1;
                  end else begin
                     a_next     = {a_reg[W-5:0], key_code[3:0]};
                     a_cnt_next = a_cnt_reg + ONE;
                  end
               end else if (is_op) begin
                  opcode_next = key_code[3:0];
                  b_next      = '0;
                  b_cnt_next  = '0;
                  ovf_next    = 1'b0;
                  fresh_next  = 1'b0;
                  state_next  = S_OP;
               end else if (is_bs) begin
                  if (fresh_reg) begin
                     a_next     = '0;
                     a_cnt_next = '0;
                     fresh_next = 1'b0;
                  end else if (a_cnt_reg != '0) begin
                     a_next     = {4'b0, a_reg[W-1:4]};
                     a_cnt_next = a_cnt_reg - ONE;
                  end
               end
            end
            S_OP: begin
               if (is_op) begin
                  opcode_next = key_code[3:0];
               end else if (is_digit) begin
                  b_next     = digit_ext;
                  b_cnt_next = ONE;
                  state_next = S_B;
               end else if (is_bs) begin
                  opcode_next = 4'd0;
                  state_next  = S_A;
               end
            end
            S_B: begin
               if (is_digit) begin
                  if (b_cnt_reg == FULL) begin
                     ovf_next = 1'b1;
                  end else begin
                     b_next     = {b_reg[W-5:0], key_code[3:0]};
                     b_cnt_next = b_cnt_reg + ONE;
                  end
               end else if (is_bs) begin
                  b_next     = {4'b0, b_reg[W-1:4]};
                  b_cnt_next = b_cnt_reg - ONE;
                  // Erasing the last B digit returns to operator selection.
                  if (b_cnt_reg <= ONE) begin
                     b_cnt_next = '0;
                     state_next = S_OP;
                  end
               end else if (is_eq) begin
                  exec_next  = 1'b1;
                  state_next = S_WAIT;
               end
            end
            default: begin
               // Key presses are dropped here; only the ALU result matters.
               if (result_valid) begin
                  a_next      = result;
                  a_cnt_next  = FULL;
                  b_next      = '0;
                  b_cnt_next  = '0;
                  opcode_next = 4'd0;
                  exec_next   = 1'b0;
                  fresh_next  = 1'b1;
                  ovf_next    = 1'b0;
                  state_next  = S_A;
               end
            end
         endcase
      end
   end

   // State registers; clear resets everything immediately, including an
   // in-flight exec_req.
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         key_q_reg  <= 1'b0;
         a_reg      <= '0;
         b_reg      <= '0;
         a_cnt_reg  <= '0;
         b_cnt_reg  <= '0;
         opcode_reg <= 4'd0;
         exec_reg   <= 1'b0;
         fresh_reg  <= 1'b0;
         ovf_reg    <= 1'b0;
         state_reg  <= S_A;
      end else begin
         key_q_reg  <= key_valid;
         a_reg      <= a_next;
         b_reg      <= b_next;
         a_cnt_reg  <= a_cnt_next;
         b_cnt_reg  <= b_cnt_next;
         opcode_reg <= opcode_next;
         exec_reg   <= exec_next;
         fresh_reg  <= fresh_next;
         ovf_reg    <= ovf_next;
         state_reg  <= state_next;
      end
   end

   assign bcd_a     = a_reg;
   assign bcd_b     = b_reg;
   assign opcode    = opcode_reg;
   assign exec_req  = exec_reg;
   assign state     = state_reg;
   assign digit_ovf = ovf_reg;

endmodule

// File: doc/calc_operand_entry.md
# calc_operand_entry

Keypad-to-operand entry controller for the BCD calculator datapath, parametrised in operand digit count. It converts single key events into a BCD operand A, operator code and BCD operand B. It adds backspace, clear-entry, overflow flagging, operator replacement and result chaining. Equals is handled as a request/valid handshake with the arithmetic unit. It sits between the keypad scanner and the ALU/display path.

## Interface
- DIGITS, 4, BCD digits per operand (≥2); operand width W = 4*DIGITS
- clk  in  1  system clock, all state on rising edge
- clear  in  1  reset, asynchronous, active-high
- key_valid  in  1  level, high while a key is held (synchronous to clk)
- key_code  in  5  key: 0–9 digit, 10–13 operator (+,−,×,÷), 14 equals, 15 backspace, 16 clear-entry, 17–31 none
- result  in  W  BCD result from ALU
- result_valid  in  1  one-cycle strobe, result is valid
- bcd_a  out  W  operand A
- bcd_b  out  W  operand B
- opcode  out  4  latched operator code (10–13), 0 when none
- exec_req  out  1  ALU request, held until result_valid
- state  out  2  FSM state for LEDs
- digit_ovf  out  1  sticky: a digit was dropped because the operand was full

## Operation
- Press detection: key_q register holds key_valid from the previous cycle. A press is key_valid & ~key_q. Exactly one event per press regardless of hold length. key_code is sampled on the press cycle only.
- Counters a_cnt and b_cnt (0..DIGITS) track entered digits. Flag fresh marks that A holds a loaded result.
- Digit entry: operand <= {operand[W-5:0], digit}; cnt+1. If cnt==DIGITS the digit is dropped, the operand is unchanged and digit_ovf is set.
- Backspace: operand <= {4'b0, operand[W-1:4]}; cnt−1. No-op when cnt==0.
- States (encoding on `state`):
  - S_A=0:
    - digit → enter into A. If fresh: A<=digit, a_cnt<=1, fresh<=0.
    - operator → opcode<=key, B<=0, b_cnt<=0, digit_ovf<=0, fresh<=0, go S_OP.
    - backspace → shift A. If fresh: A<=0, a_cnt<=0, fresh<=0.
    - equals → ignored.
  - S_OP=1:
    - operator → replace opcode.
    - digit → B<=digit, b_cnt<=1, go S_B.
    - backspace → opcode<=0, go S_A.
    - equals → ignored.
  - S_B=2:
    - digit/backspace → act on B. Backspace that empties B → go S_OP.
    - equals → exec_req<=1, go S_WAIT.
    - operator → ignored.
  - S_WAIT=3:
    - All presses are discarded, not queued.
    - On result_valid: A<=result, a_cnt<=DIGITS, B<=0, b_cnt<=0, opcode<=0, exec_req<=0, fresh<=1, digit_ovf<=0, go S_A.
- Clear-entry (16) in S_A/S_OP/S_B: A, B, opcode, counts, fresh and digit_ovf are zeroed, go S_A. It is ignored in S_WAIT so the handshake is never abandoned.
- Codes 17–31: ignored in every state.
- Only digit codes 0–9 are ever written into operands. No non-BCD nibble can appear in bcd_a/bcd_b except via `result`, which is passed through unchecked.

## Timing
- clear asserted: key_q, bcd_a, bcd_b, opcode, exec_req, digit_ovf, counters and fresh become 0 immediately; state=S_A. Reset mid-handshake drops exec_req asynchronously.
- First edge after clear deasserts is a normal cycle. If key_valid is already high, it counts as a press, because key_q resets to 0.
- Key latency: outputs update at the same rising edge that first samples key_valid=1 (key_q=0).
- exec_req rises at the equals edge and stays high through the edge that samples result_valid=1. It is low after that edge, and bcd_a=result at that edge.
- result_valid is ignored outside S_WAIT. A result_valid on the same edge as the equals press is not accepted; the earliest accepted strobe is the following edge.
- Press and result_valid on the same edge in S_WAIT: the result is taken and the press is discarded.

## Test plan
- DIGITS=4; press 1,2,3 → bcd_a=0x0123, a_cnt=3, state=0. Hold key 20 cycles → exactly one digit entered.
- Press 9,8,7,6,5 → bcd_a=0x9876, digit_ovf=1. Then backspace → 0x0987, digit_ovf still 1. Then + → digit_ovf=0, opcode=10, state=1.
- Press 4, +, −, 7 → opcode=11, bcd_b=0x0007, state=2. Backspace → bcd_b=0, state=1. Backspace → opcode=0, state=0.
- Press 1,2,+,3 then =: exec_req=1, state=3. Keys during wait are ignored. result=0x0015 strobed 5 cycles later → bcd_a=0x0015, bcd_b=0, exec_req=0, state=0. Then press ×,2 → chained A=0x0015, opcode=12. Alternatively press 8 after the result → bcd_a=0x0008.
- Clear asserted mid-cycle while state=3 and exec_req=1 → all outputs 0 without a clock edge. Clear-entry key 16 in state=2 → all zero, state=0.
- DIGITS=6 build: 7 digits entered → 6 retained, W=24, digit_ovf=1.
